// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I core.
// Fetch-stage state encoding and inter-stage bundles live here.
package riscv_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time,
// redirect handling with stale-response drop, sticky misalign fault.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word-aligned");
  end

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  instr_q, instr_n;
  logic         drop, drop_n;
  logic         misalign;
  if_id_t       if_o;

  assign misalign = redirect_valid
                  && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    drop_n  = drop;
    unique case (state)
      BOOT: state_n = REQ;
      REQ: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_req_ready) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_n = WAIT;
          drop_n  = 1'b0;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (drop || redirect_valid) begin
            drop_n  = 1'b0;
            state_n = REQ;
            if (redirect_valid) pc_n = redirect_pc;
          end else begin
            instr_n = imem_rsp_data;
            state_n = HOLD;
          end
        end else if (redirect_valid) begin
          pc_n   = redirect_pc;
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          state_n = REQ;
        end else if (!stall) begin
          pc_n    = pc + 32'(INSTR_BYTES);
          state_n = REQ;
        end
      end
      FAULT: state_n = FAULT;
      default: state_n = FAULT;
    endcase
    // misaligned target wins over every per-state rule
    if (misalign && (state inside {REQ, WAIT, HOLD})) begin
      pc_n    = redirect_pc;
      state_n = FAULT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      instr_q <= '0;
      drop    <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      drop    <= drop_n;
    end
  end

  assign if_o           = '{pc: pc, instr: instr_q};
  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign if_valid       = (state == HOLD);
  assign if_pc          = if_o.pc;
  assign if_instr       = if_o.instr;
  assign fetch_fault    = (state == FAULT);
  assign fault_pc       = fetch_fault ? pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: architectural-PC model plus
// a latency-randomised instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] WRST = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  logic        w_rst_n = 1'b1;
  logic        w_req_valid;
  logic        w_req_ready = 1'b1;
  logic [31:0] w_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'h0000_0013;
  logic        w_rv = 1'b0;
  logic [31:0] w_rpc = '0;
  logic        w_stall = 1'b0;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_fault;
  logic [31:0] w_fault_pc;

  fetch_unit #(.RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr),
    .fetch_fault(fetch_fault),
    .fault_pc(fault_pc)
  );

  fetch_unit #(.RESET_PC(WRST)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid),
    .imem_req_ready(w_req_ready),
    .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_rv),
    .redirect_pc(w_rpc),
    .stall(w_stall),
    .if_valid(w_if_valid), .if_pc(w_if_pc),
    .if_instr(w_if_instr),
    .fetch_fault(w_fault),
    .fault_pc(w_fault_pc)
  );

  int checks = 0;
  int errors = 0;

  // architectural model: program counter, fault and boot flags
  logic [31:0] mpc;
  bit          mfault;
  bit          mboot;
  // memory model: one pending response
  bit          pend;
  int          pcnt;
  logic [31:0] paddr;
  int          cyc;
  int          idle;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } pres_t;
  pres_t       pq[$];
  logic [31:0] rq[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Entered and left at a negedge; the DUT acts on the posedge between.
  task automatic step(input bit rv, input logic [31:0] rpc,
                      input bit st, input bit rdy, input int lat);
    bit rsp;
    bit acc;
    bit cons;
    rsp = pend && (pcnt == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memf(paddr) : 32'hDEAD_BEEF;
    imem_req_ready = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    checks++;
    if (fetch_fault !== mfault) begin
      errors++;
      $display("FAIL fault_flag cyc %0d: got %b want %b",
               cyc, fetch_fault, mfault);
    end
    if (mfault) begin
      checks++;
      if (fault_pc !== mpc) begin
        errors++;
        $display("FAIL fault_pc: got %h want %h", fault_pc, mpc);
      end
    end
    if (imem_req_valid === 1'b1) begin
      checks++;
      if (mboot || mfault || pend) begin
        errors++;
        $display("FAIL req_illegal cyc %0d: got 1 want 0 (boot %b fault %b pend %b)",
                 cyc, mboot, mfault, pend);
      end
      checks++;
      if (imem_addr !== mpc) begin
        errors++;
        $display("FAIL req_addr cyc %0d: got %h want %h",
                 cyc, imem_addr, mpc);
      end
    end
    if (if_valid === 1'b1) begin
      checks++;
      if (mfault || if_pc !== mpc || if_instr !== memf(mpc)) begin
        errors++;
        $display("FAIL present cyc %0d: got pc %h instr %h want pc %h instr %h",
                 cyc, if_pc, if_instr, mpc, memf(mpc));
      end
      pq.push_back('{if_pc, cyc});
    end
    acc  = imem_req_valid && rdy;
    cons = if_valid && !st && !rv;
    if (!mboot && !mfault && rv) begin
      mpc    = rpc;
      mfault = (rpc[1:0] != 2'b00);
    end else if (!mfault && cons) begin
      mpc = mpc + 32'd4;
    end
    if (rsp) pend = 1'b0;
    else if (pend) pcnt--;
    if (acc) begin
      pend  = 1'b1;
      paddr = imem_addr;
      pcnt  = lat - 1;
      rq.push_back(imem_addr);
    end
    idle  = (if_valid || mfault || rv) ? 0 : idle + 1;
    mboot = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic zstep();
    step(1'b0, 32'h0, 1'b0, 1'b1, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mpc    = RST;
    mfault = 1'b0;
    mboot  = 1'b1;
    pend   = 1'b0;
    pcnt   = 0;
    cyc    = 0;
    idle   = 0;
    pq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 ||
        if_instr !== 32'h0 || fetch_fault !== 1'b0 ||
        fault_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_zero: got req %b ifv %b instr %h flt %b fpc %h want all 0",
               imem_req_valid, if_valid, if_instr, fetch_fault, fault_pc);
    end
    checks++;
    if (imem_addr !== RST || if_pc !== RST) begin
      errors++;
      $display("FAIL reset_pc: got addr %h if_pc %h want %h",
               imem_addr, if_pc, RST);
    end
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_req: got %b want 0", imem_req_valid);
    end
    for (int i = 0; i < 10; i++) zstep();
    checks++;
    if (pq.size() < 3) begin
      errors++;
      $display("FAIL boot_count: got %0d want 3", pq.size());
    end else begin
      checks++;
      if (pq[0].pc !== RST || pq[0].cyc != 3) begin
        errors++;
        $display("FAIL boot_first: got pc %h cyc %0d want pc %h cyc 3",
                 pq[0].pc, pq[0].cyc, RST);
      end
      checks++;
      if (pq[1].pc !== RST + 32'd4 || pq[1].cyc != 6 ||
          pq[2].pc !== RST + 32'd8 || pq[2].cyc != 9) begin
        errors++;
        $display("FAIL boot_rate: got %h@%0d %h@%0d want 104@6 108@9",
                 pq[1].pc, pq[1].cyc, pq[2].pc, pq[2].cyc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] cpc;
    logic [31:0] cins;
    int n;
    do_reset();
    n = 0;
    while (!(if_valid && if_pc == 32'h104) && n < 20) begin
      zstep();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL stall_reach: got timeout want pc 104");
    end
    cpc  = if_pc;
    cins = if_instr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== cpc || if_instr !== cins ||
          imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got v %b pc %h ins %h req %b want 1 %h %h 0",
                 if_valid, if_pc, if_instr, imem_req_valid, cpc, cins);
      end
    end
    n = 0;
    while (!imem_req_valid && n < 10) begin
      zstep();
      n++;
    end
    checks++;
    if (imem_addr !== 32'h108 || imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_next: got %h want 00000108", imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int n;
    do_reset();
    n = 0;
    while (!(imem_req_valid && imem_addr == 32'h104) && n < 20) begin
      zstep();
      n++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 3);
    step(1'b1, 32'h200, 1'b0, 1'b1, 1);
    rq.delete();
    n = 0;
    while (!if_valid && n < 30) begin
      zstep();
      n++;
    end
    checks++;
    if (rq.size() == 0 || rq[0] !== 32'h200) begin
      errors++;
      $display("FAIL rdw_req: got %h want 00000200",
               rq.size() ? rq[0] : 32'hFFFF_FFFF);
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200 ||
        if_instr !== memf(32'h200)) begin
      errors++;
      $display("FAIL rdw_present: got v %b pc %h ins %h want pc 200 ins %h",
               if_valid, if_pc, if_instr, memf(32'h200));
    end
  endtask

  task automatic test_redirect_hold();
    int n;
    step(1'b1, 32'h40, 1'b0, 1'b1, 1);
    n = 0;
    while (!if_valid && n < 20) begin
      zstep();
      n++;
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
      errors++;
      $display("FAIL rdh_present: got v %b pc %h want 00000040",
               if_valid, if_pc);
    end
  endtask

  task automatic test_misaligned();
    int n;
    step(1'b1, 32'h202, 1'b0, 1'b1, 1);
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h202) begin
      errors++;
      $display("FAIL mis_fault: got %b %h want 1 00000202",
               fetch_fault, fault_pc);
    end
    for (int i = 0; i < 10; i++) begin
      step($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 1) == 1, 1'b1, 1);
      checks++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        errors++;
        $display("FAIL mis_quiet: got req %b ifv %b want 0 0",
                 imem_req_valid, if_valid);
      end
    end
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h202) begin
      errors++;
      $display("FAIL mis_sticky: got %b %h want 1 00000202",
               fetch_fault, fault_pc);
    end
    do_reset();
    checks++;
    if (fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL mis_clear: got %b want 0", fetch_fault);
    end
    n = 0;
    while (!if_valid && n < 20) begin
      zstep();
      n++;
    end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RST) begin
      errors++;
      $display("FAIL mis_recover: got v %b pc %h want %h",
               if_valid, if_pc, RST);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wq[$];
    bit wp;
    w_rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (w_addr !== WRST || w_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: got %h req %b want %h 0",
               w_addr, w_req_valid, WRST);
    end
    w_rst_n = 1'b1;
    wp = 1'b0;
    for (int i = 0; i < 20 && wq.size() < 2; i++) begin
      w_rsp_valid = wp;
      wp = 1'b0;
      if (w_req_valid) begin
        wq.push_back(w_addr);
        wp = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    w_rsp_valid = 1'b0;
    checks++;
    if (wq.size() != 2 || wq[0] !== WRST || wq[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got n %0d %h %h want FFFFFFFC 00000000",
               wq.size(), wq.size() > 0 ? wq[0] : 32'hX,
               wq.size() > 1 ? wq[1] : 32'hX);
    end
  endtask

  task automatic test_random();
    bit          rv;
    logic [31:0] rpc;
    int          fcnt;
    do_reset();
    fcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom % 10) == 0;
      rpc = $urandom & 32'hFFFF_FFFC;
      if (($urandom % 25) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(rv, rpc, ($urandom % 3) == 0, ($urandom % 4) != 0,
           int'($urandom_range(1, 4)));
      if (mfault) fcnt++;
      if (fcnt > 6) begin
        do_reset();
        fcnt = 0;
      end
      if (idle > 60) begin
        checks++;
        errors++;
        $display("FAIL liveness: got %0d idle cycles want <= 60", idle);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_misaligned();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
